// File: rtl/map_mem_pkg.sv
// Shared types for the mapper-to-memory arbiter: FSM states, channel ids and the request payload.
package map_mem_pkg;

  localparam int unsigned MAP_ADDR_BITS = 22;
  localparam int unsigned DATA_BITS     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef enum logic {
    CH_CPU = 1'b0,
    CH_PPU = 1'b1
  } chan_e;

  typedef struct packed {
    logic [MAP_ADDR_BITS-1:0] addr;
    logic                     we;
    logic [DATA_BITS-1:0]     wdata;
    chan_e                    ch;
  } mem_req_t;

endpackage

// File: rtl/map_strobe_sync.sv
// Multi-flop synchronizer for one asynchronous NES strobe, with one-cycle rise/fall pulses.
module map_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/map_mem_arb.sv
// Turns synchronized NES PRG/CHR bus cycles into single-beat memory requests, PPU over CPU.
// Optional macro MAP_MEM_ARB_PRG_WRITE_EN adds prg_we and CPU-side writes.
module map_mem_arb
  import map_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 22,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m2,
  input  logic                 ppu_rd_n,
  input  logic                 ppu_wr_n,
  input  logic [ADDR_BITS-1:0] prg_addr,
  input  logic                 prg_oe,
  input  logic [ADDR_BITS-1:0] chr_addr,
  input  logic                 chr_ce,
  input  logic                 chr_we,
`ifdef MAP_MEM_ARB_PRG_WRITE_EN
  input  logic                 prg_we,
`endif
  input  logic [7:0]           cpu_wdata,
  input  logic [7:0]           ppu_wdata,
  output logic [7:0]           cpu_rdata,
  output logic [7:0]           ppu_rdata,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 err_timeout
);

  localparam int unsigned CNT_BITS = $clog2(TIMEOUT + 1);

  logic m2_rise_c, m2_fall_c, rd_rise_c, rd_fall_c, wr_rise_c, wr_fall_c;

  map_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_m2 (
    .clk(clk), .rst_n(rst_n), .async_in(m2), .rise_c(m2_rise_c), .fall_c(m2_fall_c)
  );
  map_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .async_in(ppu_rd_n), .rise_c(rd_rise_c), .fall_c(rd_fall_c)
  );
  map_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .async_in(ppu_wr_n), .rise_c(wr_rise_c), .fall_c(wr_fall_c)
  );

  state_e               state_q, state_d;
  mem_req_t             ppu_slot_q, cpu_slot_q, inflight_q;
  mem_req_t             ppu_new_c, cpu_new_c, ppu_eff_c, cpu_eff_c;
  logic                 ppu_pend_q, cpu_pend_q;
  logic                 cpu_start_c, ppu_rd_start_c, ppu_wr_start_c, ppu_start_c;
  logic                 ppu_avail_c, cpu_avail_c, at_limit_c;
  logic                 load_ppu_c, load_cpu_c, done_c, abort_c;
  logic [CNT_BITS-1:0]  cnt_q;
  logic                 mem_req_q, err_q;
  logic [7:0]           cpu_rdata_q, ppu_rdata_q;
  logic                 unused_c;

  assign ppu_rd_start_c = rd_fall_c & chr_ce;
  assign ppu_wr_start_c = wr_fall_c & chr_ce & chr_we;
  assign ppu_start_c    = ppu_rd_start_c | ppu_wr_start_c;

  // Candidate requests built from the bus in the cycle a start is seen.
  always_comb begin
    ppu_new_c       = '0;
    ppu_new_c.addr  = MAP_ADDR_BITS'(chr_addr);
    ppu_new_c.we    = ppu_wr_start_c;
    ppu_new_c.wdata = ppu_wr_start_c ? ppu_wdata : 8'h00;
    ppu_new_c.ch    = CH_PPU;
    cpu_new_c       = '0;
    cpu_new_c.addr  = MAP_ADDR_BITS'(prg_addr);
    cpu_new_c.ch    = CH_CPU;
`ifdef MAP_MEM_ARB_PRG_WRITE_EN
    cpu_new_c.we    = prg_we;
    cpu_new_c.wdata = prg_we ? cpu_wdata : 8'h00;
`endif
  end

`ifdef MAP_MEM_ARB_PRG_WRITE_EN
  assign cpu_start_c = m2_rise_c & (prg_oe | prg_we);
  assign unused_c    = ^{m2_fall_c, rd_rise_c, wr_rise_c};
`else
  assign cpu_start_c = m2_rise_c & prg_oe;
  assign unused_c    = ^{m2_fall_c, rd_rise_c, wr_rise_c, cpu_wdata};
`endif

  // A start in the current cycle bypasses the slot so it can issue immediately.
  assign ppu_avail_c = ppu_start_c | ppu_pend_q;
  assign cpu_avail_c = cpu_start_c | cpu_pend_q;
  assign ppu_eff_c   = ppu_start_c ? ppu_new_c : ppu_slot_q;
  assign cpu_eff_c   = cpu_start_c ? cpu_new_c : cpu_slot_q;
  assign at_limit_c  = (cnt_q == CNT_BITS'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ppu_avail_c || cpu_avail_c) state_d = REQ;
      REQ:     if (mem_ack || at_limit_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ppu_c = 1'b0;
    load_cpu_c = 1'b0;
    done_c     = 1'b0;
    abort_c    = 1'b0;
    case (state_q)
      IDLE: begin
        load_ppu_c = ppu_avail_c;
        load_cpu_c = ~ppu_avail_c & cpu_avail_c;
      end
      REQ: begin
        done_c  = mem_ack;
        abort_c = ~mem_ack & at_limit_c;
      end
      default: ;
    endcase
  end

  // Pending slots, in-flight request, timeout counter and returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_pend_q  <= 1'b0;
      cpu_pend_q  <= 1'b0;
      ppu_slot_q  <= '0;
      cpu_slot_q  <= '0;
      inflight_q  <= '0;
      mem_req_q   <= 1'b0;
      cnt_q       <= '0;
      cpu_rdata_q <= 8'h00;
      ppu_rdata_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      if (load_ppu_c)       ppu_pend_q <= 1'b0;
      else if (ppu_start_c) ppu_pend_q <= 1'b1;
      if (ppu_start_c)      ppu_slot_q <= ppu_new_c;

      if (load_cpu_c)       cpu_pend_q <= 1'b0;
      else if (cpu_start_c) cpu_pend_q <= 1'b1;
      if (cpu_start_c)      cpu_slot_q <= cpu_new_c;

      if (load_ppu_c)      inflight_q <= ppu_eff_c;
      else if (load_cpu_c) inflight_q <= cpu_eff_c;

      if (load_ppu_c || load_cpu_c) mem_req_q <= 1'b1;
      else if (done_c || abort_c)   mem_req_q <= 1'b0;

      if (state_q == REQ) cnt_q <= cnt_q + CNT_BITS'(1);
      else                cnt_q <= '0;

      if (done_c && !inflight_q.we) begin
        if (inflight_q.ch == CH_PPU) ppu_rdata_q <= mem_rdata;
        else                         cpu_rdata_q <= mem_rdata;
      end

      if (abort_c) err_q <= 1'b1;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = ADDR_BITS'(inflight_q.addr);
  assign mem_we      = inflight_q.we;
  assign mem_wdata   = inflight_q.wdata;
  assign cpu_rdata   = cpu_rdata_q;
  assign ppu_rdata   = ppu_rdata_q;
  assign err_timeout = err_q;

endmodule
